probe_force_target: RTL and testbench

- Target-side endpoint for probe-based force/release/deposit from a test harness.
- Owns a free-running counter register `r` and a registered output `out` derived from it.
- Accepts override commands over a valid/ready channel and returns one read-back response per command.
- Sits inside the DUT hierarchy; gives test benches a synthesizable force path instead of simulator `force` statements.

---
 rtl/probe_force_target.sv | 208 ++++++++++++++++++++
 tb/tb_probe_force_target.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/probe_force_target.sv
// probe_force_target
// ------------------
// Target-side endpoint that lets a test harness force, release, deposit or
// read two pieces of design state through ordinary logic instead of
// simulator force statements.
//
// State owned here:
//   r_nat   free-running counter, wraps modulo 2^WIDTH
//   out_nat loads the visible r every cycle, so out lags r by one cycle
// Each target has an independent override (forced flag + force value).
// The visible value is the override when forced, the natural register
// otherwise.
//
// Ports:
//   clock, reset            single clock, synchronous active-high reset
//   cmd_valid/cmd_ready     command channel (ready only while idle)
//   cmd_op                  00 READ, 01 FORCE, 10 RELEASE, 11 DEPOSIT
//   cmd_target              0 = r, 1 = out
//   cmd_data                value for FORCE / DEPOSIT
//   rsp_valid/rsp_ready     one response per accepted command
//   rsp_data, rsp_forced    visible value / force state after the command
//   r, out                  visible values
//   r_forced, out_forced    override flags
//
// Every command walks IDLE -> APPLY -> RESPOND -> IDLE, three cycles minimum.
// The visible values are kept in registers that are loaded with the
// next-cycle value, so r/out and the response carry the same data in the
// cycle after APPLY.
module probe_force_target #(
  parameter int                 WIDTH     = 16,
  parameter logic [WIDTH-1:0]   R_RESET   = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0]   OUT_RESET = {WIDTH{1'b0}}
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic             cmd_target,
  input  logic [WIDTH-1:0] cmd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_forced,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] out,
  output logic             r_forced,
  output logic             out_forced
);

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_FORCE   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;
  localparam logic [1:0] OP_DEPOSIT = 2'b11;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_APPLY   = 2'b01,
    ST_RESPOND = 2'b10
  } state_t;

  state_t           state_r;
  logic [1:0]       op_r;
  logic             target_r;
  logic [WIDTH-1:0] data_r;

  logic [WIDTH-1:0] r_nat_r,    out_nat_r;
  logic [WIDTH-1:0] r_fval_r,   out_fval_r;
  logic             r_forced_r, out_forced_r;
  logic [WIDTH-1:0] r_vis_r,    out_vis_r;

  logic             cmd_ready_r;
  logic             rsp_valid_r;
  logic [WIDTH-1:0] rsp_data_r;
  logic             rsp_forced_r;

  logic [WIDTH-1:0] r_nat_s,    out_nat_s;
  logic [WIDTH-1:0] r_fval_s,   out_fval_s;
  logic             r_forced_s, out_forced_s;
  logic [WIDTH-1:0] r_vis_s,    out_vis_s;
  logic [WIDTH-1:0] rsp_data_s;
  logic             rsp_forced_s;

  assign cmd_ready  = cmd_ready_r;
  assign rsp_valid  = rsp_valid_r;
  assign rsp_data   = rsp_data_r;
  assign rsp_forced = rsp_forced_r;
  assign r          = r_vis_r;
  assign out        = out_vis_r;
  assign r_forced   = r_forced_r;
  assign out_forced = out_forced_r;

  // Next-cycle natural/override state, with the latched command applied in APPLY.
  always_comb begin
    r_nat_s      = r_nat_r + ONE;
    out_nat_s    = r_vis_r;
    r_fval_s     = r_fval_r;
    out_fval_s   = out_fval_r;
    r_forced_s   = r_forced_r;
    out_forced_s = out_forced_r;
    if (state_r == ST_APPLY) begin
      case (op_r)
        OP_FORCE: begin
          if (target_r) begin
            out_forced_s = 1'b1;
            out_fval_s   = data_r;
          end else begin
            r_forced_s = 1'b1;
            r_fval_s   = data_r;
          end
        end
        OP_RELEASE: begin
          if (target_r) begin
            out_forced_s = 1'b0;
          end else begin
            r_forced_s = 1'b0;
          end
        end
        // A deposit replaces this cycle's natural update; if the target is
        // forced it stays hidden behind the override until release.
        OP_DEPOSIT: begin
          if (target_r) begin
            out_nat_s = data_r;
          end else begin
            r_nat_s = data_r;
          end
        end
        OP_READ: begin
          r_nat_s = r_nat_r + ONE;
        end
        default: begin
          r_nat_s = r_nat_r + ONE;
        end
      endcase
    end else begin
      out_nat_s = r_vis_r;
    end
    r_vis_s      = r_forced_s   ? r_fval_s   : r_nat_s;
    out_vis_s    = out_forced_s ? out_fval_s : out_nat_s;
    rsp_data_s   = target_r ? out_vis_s    : r_vis_s;
    rsp_forced_s = target_r ? out_forced_s : r_forced_s;
  end

  // Datapath registers and command FSM with registered handshake outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_READ;
      target_r     <= 1'b0;
      data_r       <= ZERO;
      r_nat_r      <= R_RESET;
      out_nat_r    <= OUT_RESET;
      r_fval_r     <= ZERO;
      out_fval_r   <= ZERO;
      r_forced_r   <= 1'b0;
      out_forced_r <= 1'b0;
      r_vis_r      <= R_RESET;
      out_vis_r    <= OUT_RESET;
      cmd_ready_r  <= 1'b1;
      rsp_valid_r  <= 1'b0;
      rsp_data_r   <= ZERO;
      rsp_forced_r <= 1'b0;
    end else begin
      r_nat_r      <= r_nat_s;
      out_nat_r    <= out_nat_s;
      r_fval_r     <= r_fval_s;
      out_fval_r   <= out_fval_s;
      r_forced_r   <= r_forced_s;
      out_forced_r <= out_forced_s;
      r_vis_r      <= r_vis_s;
      out_vis_r    <= out_vis_s;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_r) begin
            op_r        <= cmd_op;
            target_r    <= cmd_target;
            data_r      <= cmd_data;
            cmd_ready_r <= 1'b0;
            state_r     <= ST_APPLY;
          end
        end
        ST_APPLY: begin
          rsp_data_r   <= rsp_data_s;
          rsp_forced_r <= rsp_forced_s;
          rsp_valid_r  <= 1'b1;
          state_r      <= ST_RESPOND;
        end
        // Response is held until consumed; counting carries on meanwhile.
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b1;
            state_r     <= ST_IDLE;
          end
        end
        default: begin
          rsp_valid_r <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_probe_force_target.sv
// Self-checking bench for probe_force_target. Expected responses are queued
// when a command is issued and compared when the response handshake occurs;
// live r/out/flag values are checked directly against bench-computed values.
module tb_probe_force_target;

  localparam int WIDTH = 16;
  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_FORCE   = 2'b01;
  localparam logic [1:0] OP_RELEASE = 2'b10;
  localparam logic [1:0] OP_DEPOSIT = 2'b11;

  logic             clock;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic             cmd_target;
  logic [WIDTH-1:0] cmd_data;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_forced;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] out;
  logic             r_forced;
  logic             out_forced;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             forced;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;  // edges since reset: the natural r count while undeposited

  probe_force_target dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_target (cmd_target),
    .cmd_data   (cmd_data),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_forced (rsp_forced),
    .r          (r),
    .out        (out),
    .r_forced   (r_forced),
    .out_forced (out_forced)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bench-side count of cycles since the last reset edge.
  always @(posedge clock) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: compare each consumed response with the oldest expectation.
  always @(negedge clock) begin
    if (!reset && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        check_val("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check_val("rsp_data", 32'(rsp_data), 32'(e.data));
        check_val("rsp_forced", 32'(rsp_forced), 32'(e.forced));
      end
    end
  end

  task automatic push_exp(input logic [WIDTH-1:0] d, input logic f);
    exp_t e;
    e.data = d;
    e.forced = f;
    exp_q.push_back(e);
  endtask

  // Offer one command; returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic tgt, input logic [WIDTH-1:0] d);
    int budget;
    budget = 50;
    while (!cmd_ready && budget > 0) begin
      @(posedge clock); #1;
      budget--;
    end
    if (budget == 0) check_val("send_timeout", 32'd1, 32'd0);
    cmd_valid  = 1'b1;
    cmd_op     = op;
    cmd_target = tgt;
    cmd_data   = d;
    @(posedge clock); #1;
    cmd_valid  = 1'b0;
  endtask

  task automatic wait_idle();
    int budget;
    budget = 50;
    do begin
      @(posedge clock); #1;
      budget--;
    end while (!cmd_ready && budget > 0);
    if (!cmd_ready) check_val("idle_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_READ; cmd_target = 1'b0;
    cmd_data = '0; rsp_ready = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Reset state and natural counting: r=0,1,2,3 out=0,0,1,2
    for (int i = 0; i < 4; i++) begin
      check_val("idle_r", 32'(r), 32'(i));
      check_val("idle_out", 32'(out), (i == 0) ? 32'd0 : 32'(i - 1));
      check_val("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      check_val("idle_cmd_ready", 32'(cmd_ready), 32'd1);
      @(posedge clock); #1;
    end

    // FORCE r=5: visible and answered two cycles after accept, out follows
    send(OP_FORCE, 1'b0, 16'h0005);
    push_exp(16'h0005, 1'b1);
    check_val("apply_cmd_ready", 32'(cmd_ready), 32'd0);
    @(posedge clock); #1;
    check_val("force_r", 32'(r), 32'h0005);
    check_val("force_r_flag", 32'(r_forced), 32'd1);
    check_val("force_rsp_valid", 32'(rsp_valid), 32'd1);
    @(posedge clock); #1;
    check_val("force_out_follow", 32'(out), 32'h0005);
    repeat (10) @(posedge clock);
    #1;
    send(OP_READ, 1'b0, 16'h0000);
    push_exp(16'h0005, 1'b1);
    wait_idle();

    // Independent overrides: forcing out leaves r alone
    send(OP_FORCE, 1'b0, 16'h0003);
    push_exp(16'h0003, 1'b1);
    wait_idle();
    send(OP_FORCE, 1'b1, 16'h007B);
    push_exp(16'h007B, 1'b1);
    wait_idle();
    check_val("ind_out", 32'(out), 32'h007B);
    check_val("ind_out_flag", 32'(out_forced), 32'd1);
    check_val("ind_r", 32'(r), 32'h0003);
    check_val("ind_r_flag", 32'(r_forced), 32'd1);
    send(OP_READ, 1'b0, 16'h0000);
    push_exp(16'h0003, 1'b1);
    wait_idle();
    // Releasing out exposes out_nat, which has been loading the forced r
    send(OP_RELEASE, 1'b1, 16'h0000);
    push_exp(16'h0003, 1'b0);
    wait_idle();
    check_val("rel_out_flag", 32'(out_forced), 32'd0);

    // Re-force r, let it sit, release: r returns to the background count
    send(OP_FORCE, 1'b0, 16'h1234);
    push_exp(16'h1234, 1'b1);
    wait_idle();
    repeat (20) @(posedge clock);
    #1;
    send(OP_RELEASE, 1'b0, 16'h0000);
    push_exp(16'(cyc + 1), 1'b0);
    @(posedge clock); #1;
    check_val("rel_r", 32'(r), 32'(16'(cyc)));
    check_val("rel_r_flag", 32'(r_forced), 32'd0);
    wait_idle();

    // DEPOSIT r near the top of the range: wrap through zero
    send(OP_DEPOSIT, 1'b0, 16'hFFFE);
    push_exp(16'hFFFE, 1'b0);
    @(posedge clock); #1;
    check_val("dep_r0", 32'(r), 32'h0000FFFE);
    @(posedge clock); #1;
    check_val("dep_r1", 32'(r), 32'h0000FFFF);
    check_val("dep_out1", 32'(out), 32'h0000FFFE);
    @(posedge clock); #1;
    check_val("dep_r2", 32'(r), 32'h00000000);
    wait_idle();

    // Reset during APPLY discards the command
    send(OP_FORCE, 1'b0, 16'h0AAA);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check_val("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check_val("rst_r_flag", 32'(r_forced), 32'd0);
    check_val("rst_r", 32'(r), 32'd0);
    check_val("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clock); #1;
    check_val("rst_r_next", 32'(r), 32'd1);
    check_val("rst_rsp_valid2", 32'(rsp_valid), 32'd0);

    // Backpressure: response held stable until rsp_ready
    rsp_ready = 1'b0;
    send(OP_FORCE, 1'b0, 16'h0AAA);
    push_exp(16'h0AAA, 1'b1);
    @(posedge clock); #1;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_val("bp_rsp_data", 32'(rsp_data), 32'h0AAA);
      check_val("bp_cmd_ready", 32'(cmd_ready), 32'd0);
      @(posedge clock); #1;
    end
    rsp_ready = 1'b1;
    wait_idle();
    check_val("bp_done_rsp_valid", 32'(rsp_valid), 32'd0);

    @(posedge clock); #1;
    check_val("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
